// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF engine: default parameter
// values and the measurement FSM state type.
package ro_puf_pkg;

  localparam int unsigned DEF_N_RO     = 8;
  localparam int unsigned DEF_STAGES   = 3;
  localparam int unsigned DEF_PRESCALE = 3096;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_WINDOW   = 50000;
  localparam int unsigned DEF_SETTLE   = 8;
  localparam int unsigned DEF_EXT_OSC  = 0;

  // Counter-clear pulse length in clk cycles
  localparam int unsigned CLEAR_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } puf_state_t;

endpackage

// File: rtl/ro_puf_engine_if.sv
// Challenge/response bus of the PUF engine.
//   master : requester side - drives start, challenge and resp_ready
//   slave  : engine side    - drives busy and the response fields
interface ro_puf_engine_if import ro_puf_pkg::*; #(
  parameter int unsigned N_RO   = DEF_N_RO,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  localparam int unsigned IDX_W = $clog2(N_RO);

  logic              start;
  logic [IDX_W-1:0]  chal_a;
  logic [IDX_W-1:0]  chal_b;
  logic [STAGES-1:0] chal_sel;
  logic [STAGES-1:0] chal_bx;
  logic              busy;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_bit;
  logic              resp_tie;
  logic              resp_err;
  logic              resp_sat;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;

  modport master (
    output start, chal_a, chal_b, chal_sel, chal_bx, resp_ready,
    input  busy, resp_valid, resp_bit, resp_tie, resp_err, resp_sat,
           count_a, count_b
  );

  modport slave (
    input  start, chal_a, chal_b, chal_sel, chal_bx, resp_ready,
    output busy, resp_valid, resp_bit, resp_tie, resp_err, resp_sat,
           count_a, count_b
  );

endinterface

// File: rtl/ro_channel.sv
// One PUF channel: configurable ring oscillator, PRESCALE divider and a
// saturating pulse counter with sticky saturation flag. The divider and
// counter live in the oscillator domain and are cleared asynchronously.
//   reset   : async engine reset (clears counter, divider, flag)
//   clear   : async counter clear from the engine FSM
//   en      : oscillator enable
//   sel, bx : per-slice configuration (path select, slice bypass)
//   ext_osc : bench oscillator used instead of the ring when EXT_OSC != 0
//   cnt,sat : pulse count and saturation flag
module ro_channel #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned PRESCALE = 3096,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned EXT_OSC  = 0
) (
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [STAGES-1:0] sel,
  input  logic [STAGES-1:0] bx,
  input  logic              ext_osc,
  output logic [CNT_W-1:0]  cnt,
  output logic              sat
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic          osc_clk;
  logic          cnt_en;
  logic          a_clr;
  logic [PW-1:0] pre;

  assign a_clr = reset | clear;

  if (EXT_OSC != 0) begin : g_ext
    // External source runs freely, so the enable gates counting instead
    logic unused_cfg;
    assign unused_cfg = ^{sel, bx};
    assign osc_clk    = ext_osc;
    assign cnt_en     = en;
  end else begin : g_ring
    // NAND head gives the single loop inversion; each slice is a
    // non-inverting inverter pair chosen by sel, or bypassed by bx.
    (* dont_touch = "true" *) logic [STAGES:0]   ring;
    (* dont_touch = "true" *) logic [STAGES-1:0] inv_p0, inv_p1;
    (* dont_touch = "true" *) logic [STAGES-1:0] inv_q0, inv_q1;
    (* dont_touch = "true" *) logic [STAGES-1:0] mux_o;
    logic unused_ext;

    assign ring[0] = ~(en & ring[STAGES]);
    for (genvar s = 0; s < STAGES; s++) begin : g_slice
      assign inv_p0[s]  = ~ring[s];
      assign inv_p1[s]  = ~inv_p0[s];
      assign inv_q0[s]  = ~ring[s];
      assign inv_q1[s]  = ~inv_q0[s];
      assign mux_o[s]   = sel[s] ? inv_q1[s] : inv_p1[s];
      assign ring[s+1]  = bx[s] ? ring[s] : mux_o[s];
    end

    assign osc_clk    = ring[STAGES];
    assign cnt_en     = 1'b1;
    assign unused_ext = ext_osc;
  end

  always_ff @(posedge osc_clk or posedge a_clr) begin
    if (a_clr) begin
      pre <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (cnt_en) begin
      if (pre == PW'(PRESCALE - 1)) begin
        pre <= '0;
        if (cnt == '1) sat <= 1'b1;
        else           cnt <= cnt + CNT_W'(1);
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine. A challenge picks two channels and a slice
// configuration; both oscillators run for WINDOW cycles, settle, and the
// two pulse counts are compared to produce one response bit.
//   clk     : control clock
//   reset   : asynchronous active-high reset
//   ext_osc : bench oscillator sources (used only when EXT_OSC != 0)
//   bus     : challenge/response bus (slave side)
module ro_puf_engine import ro_puf_pkg::*; #(
  parameter int unsigned N_RO     = DEF_N_RO,
  parameter int unsigned STAGES   = DEF_STAGES,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned SETTLE   = DEF_SETTLE,
  parameter int unsigned EXT_OSC  = DEF_EXT_OSC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_RO-1:0] ext_osc,
  ro_puf_engine_if.slave  bus
);

  localparam int unsigned IDX_W   = $clog2(N_RO);
  localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  puf_state_t        state;
  logic [TMR_W-1:0]  timer;

  logic [IDX_W-1:0]  a_lat;
  logic [IDX_W-1:0]  b_lat;
  logic [STAGES-1:0] sel_lat;
  logic [STAGES-1:0] bx_lat;

  logic              resp_bit_q;
  logic              resp_tie_q;
  logic              resp_err_q;
  logic              resp_sat_q;
  logic [CNT_W-1:0]  count_a_q;
  logic [CNT_W-1:0]  count_b_q;

  logic [N_RO-1:0]   ch_en;
  logic              ch_clear;
  logic [CNT_W-1:0]  ch_cnt [N_RO];
  logic [N_RO-1:0]   ch_sat;
  logic [CNT_W-1:0]  cnt_a_w;
  logic [CNT_W-1:0]  cnt_b_w;

  // Decoded from the async-reset state register, so reset drops the
  // enables and the clear at once.
  assign ch_clear = (state == ST_CLEAR);

  always_comb begin
    ch_en = '0;
    if (state == ST_RUN) begin
      ch_en[a_lat] = 1'b1;
      ch_en[b_lat] = 1'b1;
    end
  end

  for (genvar i = 0; i < N_RO; i++) begin : g_ch
    ro_channel #(
      .STAGES   (STAGES),
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W),
      .EXT_OSC  (EXT_OSC)
    ) u_ch (
      .reset   (reset),
      .clear   (ch_clear),
      .en      (ch_en[i]),
      .sel     (sel_lat),
      .bx      (bx_lat),
      .ext_osc (ext_osc[i]),
      .cnt     (ch_cnt[i]),
      .sat     (ch_sat[i])
    );
  end

  // Oscillator-domain values; registered only in COMPARE, after SETTLE
  // has left them static.
  assign cnt_a_w = ch_cnt[a_lat];
  assign cnt_b_w = ch_cnt[b_lat];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      sel_lat    <= '0;
      bx_lat     <= '0;
      resp_bit_q <= 1'b0;
      resp_tie_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_sat_q <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_lat      <= bus.chal_a;
            b_lat      <= bus.chal_b;
            sel_lat    <= bus.chal_sel;
            bx_lat     <= bus.chal_bx;
            resp_bit_q <= 1'b0;
            resp_tie_q <= 1'b0;
            resp_sat_q <= 1'b0;
            count_a_q  <= '0;
            count_b_q  <= '0;
            if (bus.chal_a == bus.chal_b) begin
              resp_err_q <= 1'b1;
              state      <= ST_DONE;
            end else begin
              resp_err_q <= 1'b0;
              timer      <= TMR_W'(CLEAR_CYCLES - 1);
              state      <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (timer == '0) begin
            timer <= TMR_W'(WINDOW - 1);
            state <= ST_RUN;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (timer == '0) begin
            timer <= TMR_W'(SETTLE - 1);
            state <= ST_SETTLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_SETTLE: begin
          if (timer == '0) state <= ST_COMPARE;
          else             timer <= timer - TMR_W'(1);
        end
        ST_COMPARE: begin
          count_a_q  <= cnt_a_w;
          count_b_q  <= cnt_b_w;
          resp_bit_q <= (cnt_a_w > cnt_b_w);
          resp_tie_q <= (cnt_a_w == cnt_b_w);
          resp_sat_q <= ch_sat[a_lat] | ch_sat[b_lat];
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.resp_valid = (state == ST_DONE);
  assign bus.resp_bit   = resp_bit_q;
  assign bus.resp_tie   = resp_tie_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_sat   = resp_sat_q;
  assign bus.count_a    = count_a_q;
  assign bus.count_b    = count_b_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine with external oscillators:
// clk 100 MHz, ext_osc[2] and [6] 100 MHz, ext_osc[5] 50 MHz, others idle.
// Oscillator edges sit 2 ns after clk edges so enable changes never
// coincide with counted edges.
module tb_ro_puf_engine;

  logic       clk;
  logic       reset;
  logic       osc100;
  logic       osc50;
  logic [7:0] ext_osc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          lat;

  ro_puf_engine_if #(.N_RO(8), .STAGES(3), .CNT_W(16)) bus ();
  ro_puf_engine_if #(.N_RO(8), .STAGES(3), .CNT_W(4))  bus_s ();

  ro_puf_engine #(
    .N_RO(8), .STAGES(3), .PRESCALE(4), .CNT_W(16),
    .WINDOW(1000), .SETTLE(8), .EXT_OSC(1)
  ) dut (
    .clk(clk), .reset(reset), .ext_osc(ext_osc), .bus(bus)
  );

  ro_puf_engine #(
    .N_RO(8), .STAGES(3), .PRESCALE(4), .CNT_W(4),
    .WINDOW(1000), .SETTLE(8), .EXT_OSC(1)
  ) dut_s (
    .clk(clk), .reset(reset), .ext_osc(ext_osc), .bus(bus_s)
  );

  assign ext_osc = {1'b0, osc100, osc50, 1'b0, 1'b0, osc100, 2'b00};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    osc100 = 1'b0;
    #7;
    forever begin
      osc100 = 1'b1; #5;
      osc100 = 1'b0; #5;
    end
  end

  initial begin
    osc50 = 1'b0;
    #7;
    forever begin
      osc50 = 1'b1; #10;
      osc50 = 1'b0; #10;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue a start, then retarget the live challenge and optionally poke
  // start while busy; returns edges counted up to resp_valid (bounded).
  task automatic do_start(input logic [2:0] a, input logic [2:0] b, input bit poke,
                          output int cycles);
    @(negedge clk);
    bus.chal_a   = a;
    bus.chal_b   = b;
    bus.chal_sel = 3'b101;
    bus.chal_bx  = 3'b010;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.chal_a   = 3'd0;
    bus.chal_b   = 3'd1;
    bus.chal_sel = 3'b010;
    cycles = 1;
    while (!bus.resp_valid && cycles < 2000) begin
      bus.start = poke && (cycles == 500);
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
  endtask

  task automatic take_resp(input string tag);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({tag, "_vdrop"}, bus.resp_valid, 0);
    chk({tag, "_idle"},  bus.busy,       0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.resp_ready = 1'b0;
    bus.chal_a     = '0;
    bus.chal_b     = '0;
    bus.chal_sel   = '0;
    bus.chal_bx    = '0;
    bus_s.start      = 1'b0;
    bus_s.resp_ready = 1'b0;
    bus_s.chal_a     = '0;
    bus_s.chal_b     = '0;
    bus_s.chal_sel   = '0;
    bus_s.chal_bx    = '0;

    // Reset state
    #12;
    chk("rst_busy",  bus.busy,       0);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_bit",   bus.resp_bit,   0);
    chk("rst_tie",   bus.resp_tie,   0);
    chk("rst_err",   bus.resp_err,   0);
    chk("rst_sat",   bus.resp_sat,   0);
    chk("rst_cnt_a", bus.count_a,    0);
    chk("rst_cnt_b", bus.count_b,    0);
    @(negedge clk);
    reset = 1'b0;

    // 100 MHz vs 50 MHz, busy start poke, 20-cycle hold
    do_start(3'd2, 3'd5, 1'b1, lat);
    chk("t1_latency", lat,          1012);
    chk("t1_cnt_a",   bus.count_a,  250);
    chk("t1_cnt_b",   bus.count_b,  125);
    chk("t1_bit",     bus.resp_bit, 1);
    chk("t1_tie",     bus.resp_tie, 0);
    chk("t1_err",     bus.resp_err, 0);
    chk("t1_sat",     bus.resp_sat, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_hold_valid", bus.resp_valid, 1);
    chk("t1_hold_cnt_a", bus.count_a,    250);
    chk("t1_hold_cnt_b", bus.count_b,    125);
    chk("t1_hold_bit",   bus.resp_bit,   1);
    take_resp("t1");
    repeat (3) @(posedge clk);
    #1;
    chk("t1_no_queue", bus.busy, 0);

    // Swapped channels
    do_start(3'd5, 3'd2, 1'b0, lat);
    chk("t2_latency", lat,          1012);
    chk("t2_cnt_a",   bus.count_a,  125);
    chk("t2_cnt_b",   bus.count_b,  250);
    chk("t2_bit",     bus.resp_bit, 0);
    chk("t2_tie",     bus.resp_tie, 0);
    take_resp("t2");

    // Equal frequencies, same phase -> exact tie
    do_start(3'd2, 3'd6, 1'b0, lat);
    chk("t3_cnt_a", bus.count_a,  250);
    chk("t3_cnt_b", bus.count_b,  250);
    chk("t3_tie",   bus.resp_tie, 1);
    chk("t3_bit",   bus.resp_bit, 0);
    take_resp("t3");

    // Identical indices -> error after one cycle
    do_start(3'd3, 3'd3, 1'b0, lat);
    chk("t4_latency", lat,          1);
    chk("t4_err",     bus.resp_err, 1);
    chk("t4_bit",     bus.resp_bit, 0);
    chk("t4_cnt_a",   bus.count_a,  0);
    chk("t4_cnt_b",   bus.count_b,  0);
    take_resp("t4");

    // Reset in the middle of RUN
    @(negedge clk);
    bus.chal_a = 3'd2;
    bus.chal_b = 3'd5;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (501) @(posedge clk);
    #1;
    chk("t5_run_busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_busy",  bus.busy,       0);
    chk("t5_rst_valid", bus.resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    do_start(3'd2, 3'd5, 1'b0, lat);
    chk("t5_latency", lat,          1012);
    chk("t5_cnt_a",   bus.count_a,  250);
    chk("t5_cnt_b",   bus.count_b,  125);
    chk("t5_bit",     bus.resp_bit, 1);
    chk("t5_err",     bus.resp_err, 0);
    take_resp("t5");

    // 4-bit counters saturate
    @(negedge clk);
    bus_s.chal_a = 3'd2;
    bus_s.chal_b = 3'd5;
    bus_s.start  = 1'b1;
    @(posedge clk); #1;
    bus_s.start  = 1'b0;
    lat = 1;
    while (!bus_s.resp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_latency", lat,            1012);
    chk("t6_cnt_a",   bus_s.count_a,  15);
    chk("t6_cnt_b",   bus_s.count_b,  15);
    chk("t6_sat",     bus_s.resp_sat, 1);
    chk("t6_tie",     bus_s.resp_tie, 1);
    chk("t6_bit",     bus_s.resp_bit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
